// File: rtl/cam_scaling_pkg.sv
// Shared widths, FSM encoding and config helpers for the camera scaler controller.
package cam_scaling_pkg;
  localparam int DIM_W   = 11;
  localparam int DIV_W   = 22;
  localparam int RATIO_W = 23;
  localparam int TMR_W   = 24;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CALC    = 3'd1,
    ST_HOLD    = 3'd2,
    ST_ARM     = 3'd3,
    ST_RUN     = 3'd4,
    ST_DRAIN   = 3'd5,
    ST_RECOVER = 3'd6
  } state_t;

  function automatic logic dim_ok(input logic [DIM_W-1:0] d);
    return d >= DIM_W'(2);
  endfunction
endpackage

// File: rtl/cam_scaling_div.sv
// Serial restoring divider, one quotient bit per cycle, fixed DIV_W-cycle latency.
module cam_scaling_div
  import cam_scaling_pkg::*;
(
  input  logic             in_pclk,
  input  logic             in_arstn,
  input  logic             i_start,
  input  logic [DIV_W-1:0] i_dividend,
  input  logic [DIM_W-1:0] i_divisor,
  output logic [DIV_W-1:0] o_quotient,
  output logic             o_done
);
  logic [DIV_W-1:0] r_dvd;
  logic [DIM_W-1:0] r_rem;
  logic [DIM_W-1:0] r_dsr;
  logic [4:0]       r_cnt;
  logic             r_done;
  logic [DIM_W:0]   w_rem_sh;
  logic             w_ge;
  logic [DIM_W-1:0] w_rem_sub;

  // top bit of the shifted remainder forces a subtract; the 11-bit difference is then exact
  assign w_rem_sh  = {r_rem, r_dvd[DIV_W-1]};
  assign w_ge      = w_rem_sh[DIM_W] || (w_rem_sh[DIM_W-1:0] >= r_dsr);
  assign w_rem_sub = w_rem_sh[DIM_W-1:0] - r_dsr;

  always_ff @(posedge in_pclk) begin
    if (!in_arstn) begin
      r_dvd  <= '0;
      r_rem  <= '0;
      r_dsr  <= '0;
      r_cnt  <= '0;
      r_done <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (r_cnt == 5'd0) begin
        if (i_start) begin
          r_dvd <= i_dividend;
          r_dsr <= i_divisor;
          r_rem <= '0;
          r_cnt <= 5'(DIV_W);
        end
      end else begin
        r_dvd <= {r_dvd[DIV_W-2:0], w_ge};
        r_rem <= w_ge ? w_rem_sub : w_rem_sh[DIM_W-1:0];
        r_cnt <= r_cnt - 5'd1;
        if (r_cnt == 5'd1) r_done <= 1'b1;
      end
    end
  end

  assign o_quotient = r_dvd;
  assign o_done     = r_done;
endmodule

// File: rtl/cam_scaling_ctrl.sv
// Run-time controller for the bilinear scaler: config handshake, ratio calculation,
// frame-aligned scaler release, input gating, drain watchdog and FIFO-error resync.
//
//  state   | meaning
//  IDLE    | no active config, scaler held in reset
//  CALC    | four serial divides on the pending config, scaler in reset
//  HOLD    | scaler reset held RST_HOLD cycles after commit
//  ARM     | scaler released, input gated until start-of-frame
//  RUN     | pixels pass through, output frames counted
//  DRAIN   | input gated, waiting for last output frame (watchdog)
//  RECOVER | scaler reset RST_HOLD cycles after FIFO error
module cam_scaling_ctrl
  import cam_scaling_pkg::*;
#(
  parameter int               FRAC_BITS = 10,
  parameter int               RST_HOLD  = 4,
  parameter logic [TMR_W-1:0] P_TIMEOUT = 24'd4000000,
  parameter int               FCNT_W    = 16
) (
  input  logic               in_pclk,
  input  logic               in_arstn,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [DIM_W-1:0]   cfg_x_total,
  input  logic [DIM_W-1:0]   cfg_y_total,
  input  logic [DIM_W-1:0]   cfg_x_scale,
  input  logic [DIM_W-1:0]   cfg_y_scale,
  input  logic               in_valid,
  input  logic [DIM_W-1:0]   in_x,
  input  logic [DIM_W-1:0]   in_y,
  input  logic               out_valid,
  input  logic [DIM_W-1:0]   out_x,
  input  logic [DIM_W-1:0]   out_y,
  input  logic               scl_overflow,
  input  logic               scl_underflow,
  output logic               scl_rstn,
  output logic               scl_in_valid,
  output logic [DIM_W-1:0]   scl_x_total,
  output logic [DIM_W-1:0]   scl_y_total,
  output logic [DIM_W-1:0]   scl_x_scale,
  output logic [DIM_W-1:0]   scl_y_scale,
  output logic [RATIO_W-1:0] scl_x_out_ratio,
  output logic [RATIO_W-1:0] scl_x_in_ratio,
  output logic [RATIO_W-1:0] scl_y_out_ratio,
  output logic [RATIO_W-1:0] scl_y_in_ratio,
  output logic               busy,
  output logic [FCNT_W-1:0]  frame_cnt,
  output logic               cfg_err,
  output logic               timeout_err,
  output logic               fifo_err
);
  localparam logic [DIV_W-1:0] SCALE = DIV_W'((1 << FRAC_BITS) - 1);

  state_t             r_state, w_state_nxt;
  logic               r_pend_vld;
  logic [DIM_W-1:0]   r_pend_xt, r_pend_yt, r_pend_xs, r_pend_ys;
  logic [DIM_W-1:0]   r_xt, r_yt, r_xs, r_ys;
  logic [RATIO_W-1:0] r_xo, r_xi, r_yo, r_yi;
  logic [DIV_W-1:0]   r_q0, r_q1, r_q2;
  logic [1:0]         r_op;
  logic               r_div_run;
  logic [TMR_W-1:0]   r_tmr;
  logic [FCNT_W-1:0]  r_frame_cnt;
  logic               r_scl_rstn, r_cfg_err, r_timeout_err, r_fifo_err;

  logic               w_cfg_fire, w_cfg_bad, w_sof, w_ieof, w_oeof, w_fifo_ev;
  logic               w_div_start, w_div_done, w_commit, w_count, w_timeout, w_scl_in_valid;
  logic [DIV_W-1:0]   w_dvd, w_quo;
  logic [DIM_W-1:0]   w_dsr, w_pend_xt_m1, w_pend_yt_m1;

  assign cfg_ready  = !r_pend_vld && (r_state inside {ST_IDLE, ST_ARM, ST_RUN});
  assign w_cfg_fire = cfg_valid && cfg_ready;
  assign w_cfg_bad  = !dim_ok(cfg_x_total) || !dim_ok(cfg_y_total) ||
                      !dim_ok(cfg_x_scale) || !dim_ok(cfg_y_scale);

  assign w_sof  = in_valid && in_x == '0 && in_y == '0;
  assign w_ieof = in_valid && in_x == r_xt - DIM_W'(1) && in_y == r_yt - DIM_W'(1);
  assign w_oeof = out_valid && out_x == r_xs - DIM_W'(1) && out_y == r_ys - DIM_W'(1);
  assign w_fifo_ev = (scl_overflow || scl_underflow) && (r_state inside {ST_ARM, ST_RUN, ST_DRAIN});

  assign w_pend_xt_m1 = r_pend_xt - DIM_W'(1);
  assign w_pend_yt_m1 = r_pend_yt - DIM_W'(1);

  always_comb begin
    w_dvd = DIV_W'(w_pend_xt_m1) * SCALE;
    w_dsr = r_pend_xs;
    case (r_op)
      2'd1: begin w_dvd = DIV_W'(r_pend_xs) * SCALE;    w_dsr = w_pend_xt_m1; end
      2'd2: begin w_dvd = DIV_W'(w_pend_yt_m1) * SCALE; w_dsr = r_pend_ys;    end
      2'd3: begin w_dvd = DIV_W'(r_pend_ys) * SCALE;    w_dsr = w_pend_yt_m1; end
      default: ;
    endcase
  end

  cam_scaling_div u_div (
    .in_pclk    (in_pclk),
    .in_arstn   (in_arstn),
    .i_start    (w_div_start),
    .i_dividend (w_dvd),
    .i_divisor  (w_dsr),
    .o_quotient (w_quo),
    .o_done     (w_div_done)
  );

  always_comb begin
    w_state_nxt    = r_state;
    w_scl_in_valid = 1'b0;
    w_div_start    = 1'b0;
    w_commit       = 1'b0;
    w_count        = 1'b0;
    w_timeout      = 1'b0;
    case (r_state)
      ST_IDLE: if (r_pend_vld) w_state_nxt = ST_CALC;
      ST_CALC: begin
        w_div_start = !r_div_run;
        if (w_div_done && r_op == 2'd3) begin
          w_commit    = 1'b1;
          w_state_nxt = ST_HOLD;
        end
      end
      ST_HOLD: if (r_tmr == '0) w_state_nxt = ST_ARM;
      ST_ARM: begin
        if (w_fifo_ev)       w_state_nxt = ST_RECOVER;
        else if (r_pend_vld) w_state_nxt = ST_CALC;
        else if (w_sof) begin
          w_state_nxt    = ST_RUN;
          w_scl_in_valid = 1'b1;
        end
      end
      ST_RUN: begin
        w_scl_in_valid = in_valid;
        if (w_fifo_ev) w_state_nxt = ST_RECOVER;
        else begin
          w_count = w_oeof;
          if (w_ieof && r_pend_vld) w_state_nxt = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (w_fifo_ev) w_state_nxt = ST_RECOVER;
        else if (w_oeof) begin
          w_count     = 1'b1;
          w_state_nxt = ST_CALC;
        end else if (r_tmr == '0) begin
          w_timeout   = 1'b1;
          w_state_nxt = ST_CALC;
        end
      end
      ST_RECOVER: if (r_tmr == '0) w_state_nxt = ST_ARM;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge in_pclk) begin
    if (!in_arstn) begin
      r_state       <= ST_IDLE;
      r_pend_vld    <= 1'b0;
      r_pend_xt     <= '0;
      r_pend_yt     <= '0;
      r_pend_xs     <= '0;
      r_pend_ys     <= '0;
      r_xt          <= '0;
      r_yt          <= '0;
      r_xs          <= '0;
      r_ys          <= '0;
      r_xo          <= '0;
      r_xi          <= '0;
      r_yo          <= '0;
      r_yi          <= '0;
      r_q0          <= '0;
      r_q1          <= '0;
      r_q2          <= '0;
      r_op          <= '0;
      r_div_run     <= 1'b0;
      r_tmr         <= '0;
      r_frame_cnt   <= '0;
      r_scl_rstn    <= 1'b0;
      r_cfg_err     <= 1'b0;
      r_timeout_err <= 1'b0;
      r_fifo_err    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cfg_err <= w_cfg_fire && w_cfg_bad;
      if (w_cfg_fire && !w_cfg_bad) begin
        r_pend_vld <= 1'b1;
        r_pend_xt  <= cfg_x_total;
        r_pend_yt  <= cfg_y_total;
        r_pend_xs  <= cfg_x_scale;
        r_pend_ys  <= cfg_y_scale;
      end else if (w_commit) begin
        r_pend_vld <= 1'b0;
      end
      if (w_div_start)     r_div_run <= 1'b1;
      else if (w_div_done) r_div_run <= 1'b0;
      if (w_div_done) begin
        case (r_op)
          2'd0:    r_q0 <= w_quo;
          2'd1:    r_q1 <= w_quo;
          2'd2:    r_q2 <= w_quo;
          default: ;
        endcase
        r_op <= r_op + 2'd1;
      end
      // dimensions and ratios switch atomically, always outside a running frame
      if (w_commit) begin
        r_xt <= r_pend_xt;
        r_yt <= r_pend_yt;
        r_xs <= r_pend_xs;
        r_ys <= r_pend_ys;
        r_xo <= {1'b0, r_q0};
        r_xi <= {1'b0, r_q1};
        r_yo <= {1'b0, r_q2};
        r_yi <= {1'b0, w_quo};
      end
      if (w_state_nxt != r_state)
        r_tmr <= (w_state_nxt == ST_DRAIN) ? P_TIMEOUT - TMR_W'(1) : TMR_W'(RST_HOLD - 1);
      else if (r_tmr != '0)
        r_tmr <= r_tmr - TMR_W'(1);
      r_scl_rstn <= w_state_nxt inside {ST_ARM, ST_RUN, ST_DRAIN};
      if (w_count)   r_frame_cnt   <= r_frame_cnt + FCNT_W'(1);
      if (w_timeout) r_timeout_err <= 1'b1;
      if (w_fifo_ev) r_fifo_err    <= 1'b1;
    end
  end

  assign scl_rstn        = r_scl_rstn;
  assign scl_in_valid    = w_scl_in_valid;
  assign scl_x_total     = r_xt;
  assign scl_y_total     = r_yt;
  assign scl_x_scale     = r_xs;
  assign scl_y_scale     = r_ys;
  assign scl_x_out_ratio = r_xo;
  assign scl_x_in_ratio  = r_xi;
  assign scl_y_out_ratio = r_yo;
  assign scl_y_in_ratio  = r_yi;
  assign busy            = r_state != ST_RUN;
  assign frame_cnt       = r_frame_cnt;
  assign cfg_err         = r_cfg_err;
  assign timeout_err     = r_timeout_err;
  assign fifo_err        = r_fifo_err;
endmodule
